// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM slave: response codes, AxSIZE encodings and the
// write/read FSM state types.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // AxSIZE encodings: log2 of bytes per beat.
  typedef enum logic [2:0] {
    Size1B   = 3'd0,
    Size2B   = 3'd1,
    Size4B   = 3'd2,
    Size8B   = 3'd3,
    Size16B  = 3'd4,
    Size32B  = 3'd5,
    Size64B  = 3'd6,
    Size128B = 3'd7
  } axi_size_e;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } w_state_e;

  typedef enum logic {
    RIdle,
    RData
  } r_state_e;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 AW/W/B/AR/R channel bundle between simple_axi_master and axi_sram_slave.
// Only the fields the slave uses are carried; burst/cache/prot/lock/qos are left to the
// master side and have no effect on the slave.
//   master modport: drives AW/W/AR payload and valids, bready, rready
//   slave modport:  drives awready, wready, B channel, arready, R channel
interface axi_sram_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awsize;
  logic [7:0]            awlen;

  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [StrbW-1:0]      wstrb;
  logic                  wlast;

  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arsize;
  logic [7:0]            arlen;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    output awvalid, awaddr, awsize, awlen,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arsize, arlen,
    input  arready,
    input  rvalid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awsize, awlen,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arsize, arlen,
    output arready,
    output rvalid, rdata, rresp, rlast,
    input  rready
  );

endinterface

// File: rtl/sram_1r1w_be.sv
// Simple dual-port RAM: one synchronous read port and one byte-enable write port.
// Contents are not reset. A read and write to the same word on one edge returns the old data.
//   clk_i    clock
//   re_i     read enable; rdata_o updates on the edge re_i is sampled high, holds otherwise
//   raddr_i  read word address
//   rdata_o  registered read data
//   we_i     write enable
//   waddr_i  write word address
//   wdata_i  write data
//   wbe_i    per-byte write enables
module sram_1r1w_be #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [WIDTH/8-1:0]       wbe_i
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    if (we_i) begin
      for (int b = 0; b < WIDTH / 8; b++) begin
        if (wbe_i[b]) begin
          mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave fronting an on-chip byte-addressable RAM. Single-beat transfers only; bursts,
// oversize beats and out-of-window addresses complete with SLVERR and never touch the RAM.
//   i_clk  clock
//   i_rst  synchronous reset, active-high; all outputs read 0 while it is asserted
//   s_axi  AW/W/B/AR/R slave channels
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000
) (
  input logic             i_clk,
  input logic             i_rst,
  axi_sram_slave_if.slave s_axi
);

  localparam int unsigned StrbW  = DATA_WIDTH / 8;
  localparam int unsigned IdxLsb = $clog2(StrbW);
  localparam int unsigned IdxW   = $clog2(MEM_DEPTH);

  typedef logic [IdxW-1:0] idx_t;

  function automatic logic access_err(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [2:0]            size,
                                      input logic [7:0]            len);
    logic below;
    logic beyond;
    below  = addr < BASE_ADDR;
    beyond = ((addr - BASE_ADDR) >> IdxLsb) >= ADDR_WIDTH'(MEM_DEPTH);
    return below || beyond || (size > Size8B) || (len != 8'd0);
  endfunction

  function automatic idx_t word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return idx_t'((addr - BASE_ADDR) >> IdxLsb);
  endfunction

  // Outputs are gated combinationally so the readies drop in the reset cycle itself and
  // come back the first cycle i_rst is low.
  logic run;
  assign run = ~i_rst;

  // ---------------------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------------------
  w_state_e w_state_q, w_state_d;
  idx_t     w_idx_q, w_idx_d;
  logic [7:0] w_len_q, w_len_d;
  logic [7:0] w_beat_q, w_beat_d;
  logic     w_err_q, w_err_d;
  logic     aw_hs, w_hs;
  logic     mem_we;

  assign s_axi.awready = run && (w_state_q == WIdle);
  assign s_axi.wready  = run && (w_state_q == WData);
  assign s_axi.bvalid  = run && (w_state_q == WResp);
  assign s_axi.bresp   = (s_axi.bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          w_idx_d   = word_idx(s_axi.awaddr);
          w_len_d   = s_axi.awlen;
          w_err_d   = access_err(s_axi.awaddr, s_axi.awsize, s_axi.awlen);
          w_beat_d  = 8'd0;
          w_state_d = WData;
        end
      end
      WData: begin
        if (w_hs) begin
          // Only a decoded-OK access reaches the RAM, and it is single-beat by definition.
          mem_we   = !w_err_q && (w_beat_q == 8'd0);
          // wlast must coincide exactly with beat len+1; either mismatch is sticky SLVERR.
          if (s_axi.wlast != (w_beat_q == w_len_q)) begin
            w_err_d = 1'b1;
          end
          w_beat_d = w_beat_q + 8'd1;
          if (s_axi.wlast) begin
            w_state_d = WResp;
          end
        end
      end
      WResp: begin
        if (s_axi.bready) begin
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_state_q <= WIdle;
      w_idx_q   <= '0;
      w_len_q   <= 8'd0;
      w_beat_q  <= 8'd0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------------------
  r_state_e r_state_q, r_state_d;
  logic [7:0] r_len_q, r_len_d;
  logic [7:0] r_beat_q, r_beat_d;
  logic     r_err_q, r_err_d;
  logic     ar_hs, r_hs;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign s_axi.arready = run && (r_state_q == RIdle);
  assign s_axi.rvalid  = run && (r_state_q == RData);
  assign s_axi.rdata   = (s_axi.rvalid && !r_err_q) ? mem_rdata : '0;
  assign s_axi.rresp   = (s_axi.rvalid && r_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.rlast   = s_axi.rvalid && (r_beat_q == r_len_q);

  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign r_hs  = s_axi.rvalid && s_axi.rready;

  always_comb begin
    r_state_d = r_state_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_err_d   = r_err_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          r_len_d   = s_axi.arlen;
          r_err_d   = access_err(s_axi.araddr, s_axi.arsize, s_axi.arlen);
          r_beat_d  = 8'd0;
          r_state_d = RData;
        end
      end
      RData: begin
        if (r_hs) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = RIdle;
          end else begin
            r_beat_d = r_beat_q + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state_q <= RIdle;
      r_len_q   <= 8'd0;
      r_beat_q  <= 8'd0;
      r_err_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_err_q   <= r_err_d;
    end
  end

  // The RAM read fires on the AR handshake edge; its output register then holds for the
  // whole response, which keeps rdata stable through rready stalls.
  sram_1r1w_be #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_sram (
    .clk_i   (i_clk),
    .re_i    (ar_hs),
    .raddr_i (word_idx(s_axi.araddr)),
    .rdata_o (mem_rdata),
    .we_i    (mem_we),
    .waddr_i (w_idx_q),
    .wdata_i (s_axi.wdata),
    .wbe_i   (s_axi.wstrb)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: a byte-level RAM model feeds expected B and R
// responses into queues; a negedge monitor compares every valid response cycle against the
// queue head and pops on handshake.
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam logic [31:0] Base = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) s_if ();

  axi_sram_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (64),
    .MEM_DEPTH  (256),
    .BASE_ADDR  (Base)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .s_axi (s_if)
  );

  typedef struct {
    logic [63:0] data;
    logic [63:0] mask;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  logic [1:0]  b_q[$];
  rbeat_t      r_q[$];
  logic [63:0] mem_m[int];
  logic [63:0] known_m[int];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          rr_toggle = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a, input logic [2:0] sz,
                                 input logic [7:0] len);
    return (a >= Base) && (((a - Base) >> 3) < 32'd256) && (sz <= 3'd3) && (len == 8'd0);
  endfunction

  // Response monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (s_if.bvalid) begin
      if (b_q.size() == 0) begin
        check("b_spurious", 64'(s_if.bvalid), 64'd0);
      end else begin
        check("bresp", 64'(s_if.bresp), 64'(b_q[0]));
        if (s_if.bready) void'(b_q.pop_front());
      end
    end
    if (s_if.rvalid) begin
      if (r_q.size() == 0) begin
        check("r_spurious", 64'(s_if.rvalid), 64'd0);
      end else begin
        check("rdata", s_if.rdata & r_q[0].mask, r_q[0].data & r_q[0].mask);
        check("rresp", 64'(s_if.rresp), 64'(r_q[0].resp));
        check("rlast", 64'(s_if.rlast), 64'(r_q[0].last));
        if (s_if.rready) void'(r_q.pop_front());
      end
    end
  end

  // rready: held high, or toggled every cycle to exercise stalls.
  initial begin
    s_if.rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s_if.rready = rr_toggle ? ~s_if.rready : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [31:0] addr, input logic [2:0] size,
                           input logic [7:0] len, input logic [63:0] data,
                           input logic [7:0] strb);
    bit ok;
    bit hs;
    int idx;
    int waited;
    ok  = addr_ok(addr, size, len);
    idx = int'((addr - Base) >> 3);
    @(posedge clk);
    #1;
    s_if.awvalid = 1'b1;
    s_if.awaddr  = addr;
    s_if.awsize  = size;
    s_if.awlen   = len;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk);
      hs = s_if.awready;
    end
    check("aw_accept", 64'(hs), 64'd1);
    b_q.push_back(ok ? RESP_OKAY : RESP_SLVERR);
    @(posedge clk);
    #1;
    s_if.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_if.wvalid = 1'b1;
      s_if.wdata  = data;
      s_if.wstrb  = strb;
      s_if.wlast  = (b == int'(len));
      hs     = 1'b0;
      waited = 0;
      for (int c = 0; c < 20 && !hs; c++) begin
        @(negedge clk);
        hs = s_if.wready;
        if (!hs) waited++;
      end
      check("w_accept", 64'(hs), 64'd1);
      if (b == 0) check("wready_lat", 64'(waited), 64'd0);
      @(posedge clk);
      #1;
    end
    s_if.wvalid = 1'b0;
    s_if.wlast  = 1'b0;
    @(negedge clk);
    check("bvalid_lat", 64'(s_if.bvalid), 64'd1);
    if (ok) begin
      if (!mem_m.exists(idx)) begin
        mem_m[idx]   = 64'd0;
        known_m[idx] = 64'd0;
      end
      for (int i = 0; i < 8; i++) begin
        if (strb[i]) begin
          mem_m[idx][i*8 +: 8]   = data[i*8 +: 8];
          known_m[idx][i*8 +: 8] = 8'hFF;
        end
      end
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [2:0] size,
                          input logic [7:0] len);
    bit ok;
    bit hs;
    int idx;
    rbeat_t e;
    ok  = addr_ok(addr, size, len);
    idx = int'((addr - Base) >> 3);
    @(posedge clk);
    #1;
    s_if.arvalid = 1'b1;
    s_if.araddr  = addr;
    s_if.arsize  = size;
    s_if.arlen   = len;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk);
      hs = s_if.arready;
    end
    check("ar_accept", 64'(hs), 64'd1);
    for (int b = 0; b <= int'(len); b++) begin
      if (ok) begin
        e.data = mem_m.exists(idx) ? mem_m[idx] : 64'd0;
        e.mask = known_m.exists(idx) ? known_m[idx] : 64'd0;
        e.resp = RESP_OKAY;
      end else begin
        e.data = 64'd0;
        e.mask = '1;
        e.resp = RESP_SLVERR;
      end
      e.last = (b == int'(len));
      r_q.push_back(e);
    end
    @(posedge clk);
    #1;
    s_if.arvalid = 1'b0;
    @(negedge clk);
    check("rvalid_lat", 64'(s_if.rvalid), 64'd1);
    for (int c = 0; c < 100 && r_q.size() != 0; c++) @(negedge clk);
    check("r_drain", 64'(r_q.size()), 64'd0);
  endtask

  initial begin
    bit hs;
    s_if.awvalid = 1'b0;
    s_if.awaddr  = '0;
    s_if.awsize  = '0;
    s_if.awlen   = '0;
    s_if.wvalid  = 1'b0;
    s_if.wdata   = '0;
    s_if.wstrb   = '0;
    s_if.wlast   = 1'b0;
    s_if.bready  = 1'b1;
    s_if.arvalid = 1'b0;
    s_if.araddr  = '0;
    s_if.arsize  = '0;
    s_if.arlen   = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 64'(s_if.awready), 64'd0);
    check("rst_wready", 64'(s_if.wready), 64'd0);
    check("rst_arready", 64'(s_if.arready), 64'd0);
    check("rst_bvalid", 64'(s_if.bvalid), 64'd0);
    check("rst_rvalid", 64'(s_if.rvalid), 64'd0);
    check("rst_rdata", s_if.rdata, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("awready_up", 64'(s_if.awready), 64'd1);
    check("arready_up", 64'(s_if.arready), 64'd1);

    // Byte write then full-word read.
    axi_write(Base + 32'd2, 3'd0, 8'd0, 64'h0000_0000_00AA_0000, 8'h04);
    axi_read(Base, 3'd3, 8'd0);

    // Full write, partial overwrite, zero-strobe no-op.
    axi_write(Base, 3'd3, 8'd0, 64'h1122_3344_5566_7788, 8'hFF);
    axi_write(Base, 3'd3, 8'd0, 64'h0000_BEEF_0000_0000, 8'h30);
    axi_read(Base, 3'd3, 8'd0);
    axi_write(Base, 3'd3, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    axi_read(Base, 3'd3, 8'd0);

    // Window boundaries and decode errors; errored writes must not disturb the RAM.
    axi_write(Base + 32'h7F8, 3'd3, 8'd0, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF);
    axi_read(Base + 32'h7F8, 3'd3, 8'd0);
    axi_read(32'h0FFF_FFF8, 3'd3, 8'd0);
    axi_read(32'h1000_0800, 3'd3, 8'd0);
    axi_read(Base, 3'd4, 8'd0);
    axi_write(32'h0FFF_FFF8, 3'd3, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hFF);
    axi_write(32'h1000_0800, 3'd3, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hFF);
    axi_write(Base + 32'h7F8, 3'd4, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hFF);
    axi_read(Base, 3'd3, 8'd0);
    axi_read(Base + 32'h7F8, 3'd3, 8'd0);

    // Bursts: four SLVERR beats with rready stalls, and a two-beat write.
    rr_toggle = 1'b1;
    axi_read(Base, 3'd3, 8'd3);
    rr_toggle = 1'b0;
    axi_write(Base, 3'd3, 8'd1, 64'h5555_AAAA_5555_AAAA, 8'hFF);
    axi_read(Base, 3'd3, 8'd0);

    // B held under backpressure while a read completes.
    s_if.bready = 1'b0;
    axi_write(Base + 32'h8, 3'd3, 8'd0, 64'h0F0F_0F0F_F0F0_F0F0, 8'hFF);
    axi_read(Base + 32'h7F8, 3'd3, 8'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bvalid_hold", 64'(s_if.bvalid), 64'd1);
    end
    @(posedge clk);
    #1;
    s_if.bready = 1'b1;
    for (int c = 0; c < 20 && b_q.size() != 0; c++) @(negedge clk);
    check("b_drain", 64'(b_q.size()), 64'd0);
    axi_read(Base + 32'h8, 3'd3, 8'd0);

    // Reset in W_DATA abandons the write.
    @(posedge clk);
    #1;
    s_if.awvalid = 1'b1;
    s_if.awaddr  = Base + 32'h10;
    s_if.awsize  = 3'd3;
    s_if.awlen   = 8'd0;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk);
      hs = s_if.awready;
    end
    check("aw_accept_rst", 64'(hs), 64'd1);
    @(posedge clk);
    #1;
    s_if.awvalid = 1'b0;
    @(negedge clk);
    check("wready_pre_rst", 64'(s_if.wready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_awready", 64'(s_if.awready), 64'd0);
    check("mid_rst_wready", 64'(s_if.wready), 64'd0);
    check("mid_rst_arready", 64'(s_if.arready), 64'd0);
    check("mid_rst_bvalid", 64'(s_if.bvalid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_b_after_rst", 64'(s_if.bvalid), 64'd0);
      check("idle_wready", 64'(s_if.wready), 64'd0);
    end
    axi_write(Base + 32'h10, 3'd3, 8'd0, 64'h7777_6666_5555_4444, 8'hFF);
    axi_read(Base + 32'h10, 3'd3, 8'd0);

    repeat (3) @(negedge clk);
    check("final_b_q", 64'(b_q.size()), 64'd0);
    check("final_r_q", 64'(r_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
